// File: rtl/title_pkg.sv
// title_pkg: shared types and layout helper for the title-screen animator.
//   title_state_t : animation FSM states
//   title_mode_t  : reveal mode latched at start (3 is reserved, treated as wipe)
//   bit_idx()     : flat bitmap layout, bit = col + width*row (col 0 / row 0 at bit 0)
package title_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REVEAL = 3'd1,
        ST_HOLD   = 3'd2,
        ST_BLINK  = 3'd3,
        ST_DONE   = 3'd4
    } title_state_t;

    typedef enum logic [1:0] {
        MODE_WIPE   = 2'd0,
        MODE_DROP   = 2'd1,
        MODE_SCROLL = 2'd2,
        MODE_RSVD   = 2'd3
    } title_mode_t;

    function automatic int bit_idx(input int col, input int row, input int width);
        return col + width * row;
    endfunction

endpackage

// File: rtl/title_mask_gen.sv
// title_mask_gen: combinational reveal image for a given mode and step.
// Ports:
//   mode     : reveal mode (reserved value behaves as wipe)
//   step     : number of columns/rows revealed so far
//   title_in : source bitmap, flat layout col + W*row
//   mask_out : revealed bitmap, same layout
module title_mask_gen
    import title_pkg::*;
#(
    parameter int TITLE_WIDTH  = 28,
    parameter int TITLE_HEIGHT = 6,
    parameter int STEP_W       = 5
) (
    input  title_mode_t                              mode,
    input  logic [STEP_W-1:0]                        step,
    input  logic [TITLE_WIDTH*TITLE_HEIGHT-1:0]      title_in,
    output logic [TITLE_WIDTH*TITLE_HEIGHT-1:0]      mask_out
);

    logic [TITLE_WIDTH-1:0] col_mask;
    logic [TITLE_WIDTH-1:0] row_in;
    logic [TITLE_WIDTH-1:0] row_out;
    logic [STEP_W-1:0]      shamt;

    always_comb begin
        col_mask = '0;
        for (int c = 0; c < TITLE_WIDTH; c++) begin
            col_mask[c] = (STEP_W'(c) < step);
        end
        // Scrolling in from the right edge is a left shift of each row by W-step.
        shamt    = STEP_W'(TITLE_WIDTH) - step;
        row_in   = '0;
        row_out  = '0;
        mask_out = '0;
        for (int r = 0; r < TITLE_HEIGHT; r++) begin
            row_in = title_in[bit_idx(0, r, TITLE_WIDTH) +: TITLE_WIDTH];
            case (mode)
                MODE_DROP:   row_out = (STEP_W'(r) < step) ? row_in : '0;
                MODE_SCROLL: row_out = row_in << shamt;
                default:     row_out = row_in & col_mask;
            endcase
            mask_out[bit_idx(0, r, TITLE_WIDTH) +: TITLE_WIDTH] = row_out;
        end
    end

endmodule

// File: rtl/title_anim.sv
// title_anim: animates the static title bitmap (reveal, hold, blink, done),
// paced by the frame tick. title_out is registered and tracks title_in live.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   tick       : one-cycle frame pulse
//   start      : begin animation (ignored while busy)
//   skip       : jump to DONE (only while busy; wins over start then)
//   mode       : reveal mode, latched at start
//   title_in   : source bitmap, title_out: animated bitmap
//   busy       : high in REVEAL/HOLD/BLINK, done: one-cycle pulse entering DONE
// Build option: define TITLE_ANIM_BLINK_EN to include the BLINK phase.
//
// state  | meaning
// IDLE   | output blank, waiting for start
// REVEAL | image revealed one column/row per STEP_TICKS ticks
// HOLD   | full image for HOLD_TICKS ticks
// BLINK  | alternating blank/full phases of BLINK_TICKS ticks
// DONE   | full image, waiting for a restart
module title_anim
    import title_pkg::*;
#(
    parameter int TITLE_WIDTH  = 28,
    parameter int TITLE_HEIGHT = 6,
    parameter int STEP_TICKS   = 2,
    parameter int HOLD_TICKS   = 60,
    parameter int BLINK_TICKS  = 15,
    parameter int BLINK_COUNT  = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   tick,
    input  logic                                   start,
    input  logic                                   skip,
    input  logic [1:0]                             mode,
    input  logic [TITLE_WIDTH*TITLE_HEIGHT-1:0]    title_in,
    output logic [TITLE_WIDTH*TITLE_HEIGHT-1:0]    title_out,
    output logic                                   busy,
    output logic                                   done
);

    localparam int N     = TITLE_WIDTH * TITLE_HEIGHT;
    localparam int SMAX  = (TITLE_WIDTH > TITLE_HEIGHT) ? TITLE_WIDTH : TITLE_HEIGHT;
    localparam int SW    = $clog2(SMAX + 1);
    localparam int TMAX0 = (STEP_TICKS > HOLD_TICKS) ? STEP_TICKS : HOLD_TICKS;
    localparam int TMAX  = (TMAX0 > BLINK_TICKS) ? TMAX0 : BLINK_TICKS;
    localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

    if (STEP_TICKS < 1 || HOLD_TICKS < 1 || BLINK_TICKS < 1 || BLINK_COUNT < 1) begin : g_bad_param
        $error("title_anim: tick and count parameters must be at least 1");
    end

    title_state_t      state_q, state_d;
    title_mode_t       mode_q, mode_d;
    logic [SW-1:0]     step_q, step_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [N-1:0]      title_out_q, title_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SW-1:0]     step_last;
    logic [N-1:0]      mask_img;

`ifdef TITLE_ANIM_BLINK_EN
    localparam int PW = (2 * BLINK_COUNT > 1) ? $clog2(2 * BLINK_COUNT) : 1;
    logic [PW-1:0]     phase_q, phase_d;
`endif

    title_mask_gen #(
        .TITLE_WIDTH  (TITLE_WIDTH),
        .TITLE_HEIGHT (TITLE_HEIGHT),
        .STEP_W       (SW)
    ) u_mask (
        .mode     (mode_d),
        .step     (step_d),
        .title_in (title_in),
        .mask_out (mask_img)
    );

    assign step_last = (mode_q == MODE_DROP) ? SW'(TITLE_HEIGHT) : SW'(TITLE_WIDTH);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        step_d  = step_q;
        tcnt_d  = tcnt_q;
`ifdef TITLE_ANIM_BLINK_EN
        phase_d = phase_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_REVEAL;
                    mode_d  = title_mode_t'(mode);
                    step_d  = '0;
                    tcnt_d  = '0;
                end
            end
            ST_REVEAL: begin
                if (skip) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    if (tcnt_q == TW'(STEP_TICKS - 1)) begin
                        tcnt_d = '0;
                        step_d = step_q + SW'(1);
                        if (step_q + SW'(1) == step_last) begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (skip) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    if (tcnt_q == TW'(HOLD_TICKS - 1)) begin
                        tcnt_d = '0;
`ifdef TITLE_ANIM_BLINK_EN
                        state_d = ST_BLINK;
                        phase_d = '0;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
`ifdef TITLE_ANIM_BLINK_EN
            ST_BLINK: begin
                if (skip) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    if (tcnt_q == TW'(BLINK_TICKS - 1)) begin
                        tcnt_d = '0;
                        if (phase_q == PW'(2 * BLINK_COUNT - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            phase_d = phase_q + PW'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Outputs are computed from the next state so the image changes on the same edge.
        busy_d = (state_d == ST_REVEAL) || (state_d == ST_HOLD) || (state_d == ST_BLINK);
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
        case (state_d)
            ST_REVEAL: title_out_d = mask_img;
            ST_HOLD:   title_out_d = title_in;
`ifdef TITLE_ANIM_BLINK_EN
            ST_BLINK:  title_out_d = phase_d[0] ? title_in : '0;
`endif
            ST_DONE:   title_out_d = title_in;
            default:   title_out_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_WIPE;
            step_q      <= '0;
            tcnt_q      <= '0;
            title_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef TITLE_ANIM_BLINK_EN
            phase_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            step_q      <= step_d;
            tcnt_q      <= tcnt_d;
            title_out_q <= title_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef TITLE_ANIM_BLINK_EN
            phase_q     <= phase_d;
`endif
        end
    end

    assign title_out = title_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/title_anim.md
# title_anim

Sequential title-screen animator that sits between the static title bitmap generator and the VGA renderer. It takes a flat `TITLE_WIDTH x TITLE_HEIGHT` bitmap and outputs a registered, animated copy of it, paced by the frame tick. Animation runs in order: reveal (wipe, drop or scroll), hold, optional blink, done. The output holds the full image until the next start.

## Interface
- `TITLE_WIDTH`, 28: bitmap columns.
- `TITLE_HEIGHT`, 6: bitmap rows.
- `STEP_TICKS`, 2: frame ticks per reveal step, ≥1.
- `HOLD_TICKS`, 60: frame ticks full image is held after reveal, ≥1.
- `BLINK_TICKS`, 15: frame ticks per blink half-period, ≥1.
- `BLINK_COUNT`, 3: number of off/on blink pairs, ≥1.
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle frame pulse (vsync-derived).
- `start` in 1: one-cycle request to begin the animation.
- `skip` in 1: jump straight to DONE.
- `mode` in 2: reveal mode, latched at start.
- `title_in` in `TITLE_WIDTH*TITLE_HEIGHT`: source bitmap. Bit index is `col + TITLE_WIDTH*row`, with col 0 and row 0 at bit 0.
- `title_out` out `TITLE_WIDTH*TITLE_HEIGHT`: animated bitmap, registered, same layout.
- `busy` out 1: high in REVEAL, HOLD and BLINK.
- `done` out 1: one-cycle pulse on entry to DONE.

## Operation
- States are IDLE, REVEAL, HOLD, BLINK and DONE.
- Reset sets state to IDLE, `title_out` to 0, `busy` to 0 and `done` to 0. All counters clear to 0.
- **IDLE:** `title_out` is 0. On `start`, go to REVEAL, latch `mode` and clear the step and tick counters.
- **REVEAL:** the tick counter counts ticks. When it reaches `STEP_TICKS-1`, it clears and `step` increments.
  - The reveal ends at `LAST` = `TITLE_WIDTH` for wipe/scroll and `TITLE_HEIGHT` for drop.
  - When `step` reaches `LAST`, go to HOLD.
- **Reveal modes:**
  - 0 = WIPE: columns `c < step` are shown and the rest are 0.
  - 1 = DROP: rows `r < step` are shown.
  - 2 = SCROLL: output column `c` equals input column `c-(TITLE_WIDTH-step)` when `c ≥ TITLE_WIDTH-step`, otherwise 0.
  - 3 is reserved and behaves as WIPE.
  - At `step==LAST`, the output equals `title_in` in every mode.
- **HOLD:** show the full image for `HOLD_TICKS` ticks, then go to BLINK, or to DONE if blink is compiled out.
- **BLINK:** `2*BLINK_COUNT` phases of `BLINK_TICKS` ticks each. The first phase is blank and phases alternate blank/full. After the last phase (which is full), go to DONE.
- **DONE:** `title_out` equals `title_in` and `busy` is 0. `start` restarts at REVEAL with a fresh `mode` latch.
- `title_in` is read live every cycle; it is not latched.
- `skip` in REVEAL/HOLD/BLINK goes to DONE on the next edge. `skip` is ignored in IDLE and DONE.
- `start` is ignored while `busy`.
- `start` and `skip` in the same cycle: `start` wins in IDLE/DONE, `skip` wins while busy.
- Counter widths: step is `$clog2(max(TITLE_WIDTH,TITLE_HEIGHT)+1)` bits. The tick counter is `$clog2(max(STEP_TICKS,HOLD_TICKS,BLINK_TICKS))` bits, minimum 1.

## Timing
- All outputs are registered. `title_out` reflects a state/step change on the same edge that makes the change, so there are zero extra cycles after the tick edge.
- `start` at edge N sets `busy` high at edge N. The first step fires on tick number `STEP_TICKS` after start.
- A `tick` in the same cycle as an accepted `start` is not counted.
- `done` is high for exactly one cycle, on the edge that enters DONE, whether by normal end or by skip.
- Total ticks to DONE = `STEP_TICKS*LAST + HOLD_TICKS + 2*BLINK_COUNT*BLINK_TICKS`.
- Deasserting `rst_n` mid-animation forces the reset values immediately, without waiting for a clock edge.

## Configuration
- `TITLE_ANIM_BLINK_EN`: when defined, the BLINK state and its counter are built.
- When undefined, HOLD goes directly to DONE, the `BLINK_*` parameters are unused, and total ticks = `STEP_TICKS*LAST + HOLD_TICKS`.

## Structure
- Shared package `title_pkg`: state enum `title_state_t`, mode enum `title_mode_t` (`MODE_WIPE`, `MODE_DROP`, `MODE_SCROLL`), and the bit-index layout rule.
- Sub-module `title_mask_gen`: combinational function of `(mode, step, title_in)` that produces the reveal image. It is purely combinational and instantiated once.

## Test plan
Common setup: W=28, H=6, STEP_TICKS=1, HOLD_TICKS=4, BLINK_TICKS=2, BLINK_COUNT=3, blink enabled, `title_in` set to all ones.
- WIPE: start, then 3 ticks → `title_out` has bits 0..2 of every row set. After 28 ticks → all ones and `busy`=1. After 28+4+12=44 ticks → `done` pulses once and `busy`=0.
- DROP: start with mode=1, then 2 ticks → rows 0–1 all ones and rows 2–5 zero. HOLD is entered after the 6th tick.
- SCROLL with `title_in` = only col 0 set in each row: 1 tick → bit col 27 set in every row. 28 ticks → bit col 0 set.
- BLINK: after HOLD → `title_out`=0 for 2 ticks, then full for 2 ticks, repeated 3 times. `done` comes after the last full phase.
- Skip at tick 5 of REVEAL → next cycle `title_out` equals `title_in` and `done`=1. A `start` while busy has no effect.
- `rst_n` low mid-BLINK → immediately `title_out`=0, `busy`=0, `done`=0. State returns to IDLE.
